// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard frame receiver feeding a scan-code FIFO; define PS2_PARITY_CHECK_EN to reject bad-parity frames
module ps2_rx_fifo #(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       parity_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int IW    = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]         ps2_sync;
  logic               fall;
  logic [3:0]         bit_cnt;
  logic [9:0]         shreg;
  logic [IW-1:0]      idle_cnt;
  logic               frame_end;
  logic               frame_fmt_ok;
  logic               parity_ok;
  logic               push;
  logic               pop;
  logic               wr_en;
  logic               empty;
  logic               full;
  logic [FIFO_AW:0]   wp;
  logic [FIFO_AW:0]   rp;
  logic [7:0]         mem [DEPTH];

  // Falling edge of the synchronized PS/2 clock: older sample high, newer low.
  assign fall = ps2_sync[2] & ~ps2_sync[1];

  // After ten shifts: shreg[0]=start, shreg[8:1]=data, shreg[9]=parity; the stop
  // bit is still on the wire at the 11th edge (data is stable around the edge).
  assign frame_end    = fall && (bit_cnt == 4'd10);
  assign frame_fmt_ok = frame_end && !shreg[0] && ps2_data;
  assign parity_ok    = ^shreg[9:1];

`ifdef PS2_PARITY_CHECK_EN
  assign push = frame_fmt_ok && parity_ok;

  // One-cycle pulse for a well-formed frame whose odd parity does not hold.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) parity_err <= 1'b0;
    else      parity_err <= frame_fmt_ok && !parity_ok;
  end
`else
  logic unused_parity;

  // The parity bit is captured but ignored in this build.
  assign unused_parity = parity_ok;
  assign push          = frame_fmt_ok;
  assign parity_err    = 1'b0;
`endif

  // Three-flop synchronizer for ps2_clk; resets to the idle-high bus level.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) ps2_sync <= 3'b111;
    else      ps2_sync <= {ps2_sync[1:0], ps2_clk};
  end

  // Bit collection with an idle watchdog that abandons stalled partial frames.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      bit_cnt  <= 4'd0;
      shreg    <= 10'd0;
      idle_cnt <= '0;
    end else if (fall) begin
      idle_cnt <= '0;
      if (bit_cnt == 4'd10) begin
        bit_cnt <= 4'd0;
      end else begin
        shreg   <= {ps2_data, shreg[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else if (bit_cnt != 4'd0) begin
      if (idle_cnt == IW'(TIMEOUT_CYC)) begin
        bit_cnt  <= 4'd0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign empty = (wp == rp);
  assign full  = (wp[FIFO_AW] != rp[FIFO_AW]) &&
                 (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
  assign pop   = !nextdata_n && !empty;
  assign wr_en = push && (!full || pop);

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp[FIFO_AW-1:0]] <= shreg[8:1];
  end

  // Pointer and sticky overflow bookkeeping.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (pop) begin
        rp       <= rp + 1'b1;
        overflow <= 1'b0;
      end else if (push && full) begin
        overflow <= 1'b1;
      end
    end
  end

  assign data  = mem[rp[FIFO_AW-1:0]];
  assign ready = !empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed self-checking bench for ps2_rx_fifo
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int QTR  = 12500;
  localparam int HALF = 25000;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       parity_err;

  int total = 0;
  int bad   = 0;
  int pe_cycles = 0;
  int ov_cycles = 0;

  ps2_rx_fifo #(.FIFO_AW(3), .TIMEOUT_CYC(5000)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always #500 clk = ~clk;

  always @(negedge clk) begin
    if (parity_err === 1'b1) pe_cycles++;
    if (overflow === 1'b1) ov_cycles++;
  end

  // 20 kHz PS/2 clock; pop_last aligns the 11th falling edge to clk so the
  // push cycle is known and nextdata_n can be pulsed exactly in it.
  task automatic send_frame(input logic [7:0] b, input logic flip, input logic bad_stop,
                            input int nbits, input logic pop_last);
    logic [10:0] f;
    logic        p;
    p = ~(^b) ^ flip;
    f = {~bad_stop, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (pop_last && i == 10) begin
        #QTR;
        @(negedge clk) ps2_clk = 1'b0;
        @(negedge clk);
        @(negedge clk) nextdata_n = 1'b0;
        @(negedge clk) nextdata_n = 1'b1;
        #HALF;
        ps2_clk = 1'b1;
        #QTR;
      end else begin
        #QTR;
        ps2_clk = 1'b0;
        #HALF;
        ps2_clk = 1'b1;
        #QTR;
      end
    end
    ps2_data = 1'b1;
  endtask

  task automatic pop_one;
    @(negedge clk) nextdata_n = 1'b0;
    @(negedge clk) nextdata_n = 1'b1;
  endtask

  task automatic test_reset;
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err got=%b want=0", parity_err); end
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL post_reset_ready got=%b want=0", ready); end
  endtask

  task automatic test_single;
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", ready); end
    total++; if (data !== 8'h1C) begin bad++; $display("FAIL single_data got=%h want=1c", data); end
    pop_one();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL single_pop_ready got=%b want=0", ready); end
    pop_one();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL pop_empty_ready got=%b want=0", ready); end
    send_frame(8'h2B, 1'b0, 1'b0, 11, 1'b0);
    total++; if (data !== 8'h2B) begin bad++; $display("FAIL after_empty_pop_data got=%h want=2b", data); end
    pop_one();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL after_empty_pop_ready got=%b want=0", ready); end
  endtask

  task automatic test_bad_stop;
    int pe0;
    pe0 = pe_cycles;
    send_frame(8'h33, 1'b0, 1'b1, 11, 1'b0);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL bad_stop_ready got=%b want=0", ready); end
    total++; if (pe_cycles != pe0) begin bad++; $display("FAIL bad_stop_pe got=%0d want=0", pe_cycles - pe0); end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 11, 1'b0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ovf_ready got=%b want=1", ready); end
    for (int i = 1; i <= 8; i++) begin
      total++; if (data !== 8'(i)) begin bad++; $display("FAIL ovf_data[%0d] got=%h want=%h", i, data, 8'(i)); end
      pop_one();
      if (i == 1) begin
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
      end
    end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b want=0", ready); end
  endtask

  task automatic test_full_push_pop;
    int ov0;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0, 11, 1'b0);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_ovf got=%b want=0", overflow); end
    ov0 = ov_cycles;
    send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b1);
    total++; if (ov_cycles != ov0) begin bad++; $display("FAIL pushpop_ovf_cycles got=%0d want=0", ov_cycles - ov0); end
    for (int k = 0; k < 8; k++) begin
      exp = (k < 7) ? (8'h12 + 8'(k)) : 8'h5A;
      total++; if (data !== exp) begin bad++; $display("FAIL pushpop_data[%0d] got=%h want=%h", k, data, exp); end
      pop_one();
    end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL pushpop_drained got=%b want=0", ready); end
  endtask

  task automatic test_parity;
    int pe0;
    pe0 = pe_cycles;
    send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL parity_ready got=%b want=0", ready); end
    total++; if (pe_cycles - pe0 != 1) begin bad++; $display("FAIL parity_pulse got=%0d want=1", pe_cycles - pe0); end
`else
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL parity_ready got=%b want=1", ready); end
    total++; if (data !== 8'h1C) begin bad++; $display("FAIL parity_data got=%h want=1c", data); end
    total++; if (pe_cycles != pe0) begin bad++; $display("FAIL parity_pulse got=%0d want=0", pe_cycles - pe0); end
    pop_one();
`endif
    pe0 = pe_cycles;
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
    total++; if (data !== 8'h1C) begin bad++; $display("FAIL parity_good_data got=%h want=1c", data); end
    total++; if (pe_cycles != pe0) begin bad++; $display("FAIL parity_good_pulse got=%0d want=0", pe_cycles - pe0); end
    pop_one();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL parity_drained got=%b want=0", ready); end
  endtask

  task automatic test_timeout;
    send_frame(8'hAA, 1'b0, 1'b0, 5, 1'b0);
    repeat (5200) @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL timeout_ready got=%b want=0", ready); end
    send_frame(8'hF0, 1'b0, 1'b0, 11, 1'b0);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL timeout_frame_ready got=%b want=1", ready); end
    total++; if (data !== 8'hF0) begin bad++; $display("FAIL timeout_data got=%h want=f0", data); end
    pop_one();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL timeout_single got=%b want=0", ready); end
  endtask

  task automatic test_reset_midframe;
    int pe0;
    send_frame(8'h12, 1'b0, 1'b0, 6, 1'b0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    pe0 = pe_cycles;
    send_frame(8'h12, 1'b0, 1'b0, 11, 1'b0);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", ready); end
    total++; if (data !== 8'h12) begin bad++; $display("FAIL midrst_data got=%h want=12", data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b want=0", overflow); end
    total++; if (pe_cycles != pe0) begin bad++; $display("FAIL midrst_pe got=%0d want=0", pe_cycles - pe0); end
    pop_one();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL midrst_single got=%b want=0", ready); end
  endtask

  initial begin
    clrn       = 1'b1;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    test_reset();
    test_single();
    test_bad_stop();
    test_overflow();
    test_full_push_pop();
    test_parity();
    test_timeout();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
